// File: rtl/ad_ip_jesd204_tpl_dac_pkg.sv
// Shared definitions for the TPL DAC DMA elastic buffer: FSM encoding and sample geometry.
package ad_ip_jesd204_tpl_dac_pkg;

    localparam int SAMPLE_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PREFILL = 2'd1,
        RUN     = 2'd2
    } dac_fifo_state_e;

    // Width of one DMA word covering every sample of every converter for one clk.
    function automatic int dac_word_width(input int num_channels, input int data_path_width);
        return num_channels * data_path_width * SAMPLE_WIDTH;
    endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_fifo_mem.sv
// Simple dual-port storage for the DMA FIFO: one write port and one registered read port.
// The read register doubles as the output stage, so it can also clear or hold its word.
module ad_ip_jesd204_tpl_dac_fifo_mem
    import ad_ip_jesd204_tpl_dac_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  rd_clr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    // Storage array write port, deliberately without reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read register next value: fresh word, forced zero, or hold of the previous word.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end else if (rd_clr) begin
            rd_data_d = '0;
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Read/output register; reset so the downstream sees zero immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_dma_fifo.sv
// Elastic buffer between the DMA stream and the TPL DAC channel muxes: prefill, then one
// word per clk, with underflow detection and zero/hold substitution when starved.
module ad_ip_jesd204_tpl_dac_dma_fifo
    import ad_ip_jesd204_tpl_dac_pkg::*;
#(
    parameter int NUM_CHANNELS    = 1,
    parameter int DATA_PATH_WIDTH = 4,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int START_LEVEL     = 8,
    parameter int UNDERFLOW_ZERO  = 1
) (
    input  logic                                                      clk,
    input  logic                                                      reset,
    input  logic                                                      enable,
    input  logic                                                      s_valid,
    output logic                                                      s_ready,
    input  logic [dac_word_width(NUM_CHANNELS, DATA_PATH_WIDTH)-1:0]  s_data,
    output logic [dac_word_width(NUM_CHANNELS, DATA_PATH_WIDTH)-1:0]  dma_data,
    output logic                                                      dma_valid,
    output logic                                                      underflow,
    output logic                                                      underflow_sticky,
    input  logic                                                      underflow_clr,
    output logic [FIFO_DEPTH_LOG2:0]                                  fifo_level
);

    localparam int W     = dac_word_width(NUM_CHANNELS, DATA_PATH_WIDTH);
    localparam int AW    = FIFO_DEPTH_LOG2;
    localparam int LW    = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

    dac_fifo_state_e state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            s_ready_q, s_ready_d;
    logic            dma_valid_q, dma_valid_d;
    logic            underflow_q, underflow_d;
    logic            sticky_q, sticky_d;
    logic            push;
    logic            pop;
    logic            rd_clr;

    // Next-state, pointer, level and flag computation.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        dma_valid_d = 1'b0;
        underflow_d = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        rd_clr      = 1'b1;

        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = PREFILL;
                end
                PREFILL: begin
                    push = s_valid && s_ready_q;
                    if (level_q >= LW'(START_LEVEL)) begin
                        state_d = RUN;
                    end else begin
                        state_d = PREFILL;
                    end
                end
                RUN: begin
                    // Starved cycles keep the old word only in hold mode.
                    push        = s_valid && s_ready_q;
                    pop         = (level_q != '0);
                    dma_valid_d = pop;
                    underflow_d = !pop;
                    rd_clr      = !pop && (UNDERFLOW_ZERO != 0);
                    state_d     = RUN;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (state_d == IDLE) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            level_d  = level_q + LW'(push) - LW'(pop);
        end

        s_ready_d = (state_d != IDLE) && (level_d != LW'(DEPTH));

        if (underflow_d) begin
            sticky_d = 1'b1;
        end else if (underflow_clr) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            s_ready_q   <= 1'b0;
            dma_valid_q <= 1'b0;
            underflow_q <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            s_ready_q   <= s_ready_d;
            dma_valid_q <= dma_valid_d;
            underflow_q <= underflow_d;
            sticky_q    <= sticky_d;
        end
    end

    ad_ip_jesd204_tpl_dac_fifo_mem #(
        .DATA_WIDTH (W),
        .ADDR_WIDTH (AW)
    ) i_mem (
        .clk     (clk),
        .rst     (reset),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (s_data),
        .rd_en   (pop),
        .rd_clr  (rd_clr),
        .rd_addr (rd_ptr_q),
        .rd_data (dma_data)
    );

    assign s_ready          = s_ready_q;
    assign dma_valid        = dma_valid_q;
    assign underflow        = underflow_q;
    assign underflow_sticky = sticky_q;
    assign fifo_level       = level_q;

endmodule
